// File: rtl/key_debounce_conditioner.sv
// Debounces active-low pushbutton pins into synchronous active-high levels,
// with one-cycle press/release pulses and a sticky per-key press-capture flag.
module key_debounce_conditioner #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_raw_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] press_capture,
  input  logic [NUM_KEYS-1:0] capture_clr
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {STABLE = 1'b0, VERIFY = 1'b1} state_e;

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] sync;
  logic [NUM_KEYS-1:0] level_q;
  logic [NUM_KEYS-1:0] press_q;
  logic [NUM_KEYS-1:0] release_q;
  logic [NUM_KEYS-1:0] capture_q;
  logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
  state_e              state_q [NUM_KEYS];

  // Plain two-flop chain; resets to "released" so no spurious press at reset exit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_raw_n;
      sync2_q <= sync1_q;
    end
  end

  assign sync = ~sync2_q;

  // Per-key debounce FSM: accept a change only after it holds for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        cnt_q[i]   <= '0;
        state_q[i] <= STABLE;
      end
    end else begin
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        press_q[i]   <= 1'b0;
        release_q[i] <= 1'b0;
        if (state_q[i] == STABLE) begin
          if (sync[i] != level_q[i]) begin
            state_q[i] <= VERIFY;
            cnt_q[i]   <= CNT_W'(1);
          end else begin
            cnt_q[i] <= '0;
          end
        end else begin
          if (sync[i] == level_q[i]) begin
            state_q[i] <= STABLE;
            cnt_q[i]   <= '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            level_q[i]   <= sync[i];
            press_q[i]   <= sync[i];
            release_q[i] <= ~sync[i];
            state_q[i]   <= STABLE;
            cnt_q[i]     <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Set has priority over clear so a press coinciding with a clear is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture_q <= '0;
    end else begin
      capture_q <= (capture_q & ~capture_clr) | press_q;
    end
  end

  assign key_level     = level_q;
  assign key_press     = press_q;
  assign key_release   = release_q;
  assign press_capture = capture_q;

endmodule
